// File: rtl/discrete_555_pkg.sv
`default_nettype none
// ============================================================================
// Module   : discrete_555_pkg
// Purpose  : Types and default fixed-point constants shared by the discrete
//            555 timer models.
// Revision : 1.0 - initial release
// ============================================================================
package discrete_555_pkg;

    // Default voltage word format: signed Q(WIDTH-FRAC).FRAC, 1.0 V = 2^FRAC.
    localparam int DEFAULT_WIDTH = 24;
    localparam int DEFAULT_FRAC  = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHARGE    = 2'd1,
        DISCHARGE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rc_step.sv
`default_nettype none
// ============================================================================
// Module   : rc_step
// Purpose  : One explicit-Euler step of an RC node toward a target voltage,
//            with a guaranteed minimum step of one LSB and saturation of the
//            result to [0, vmax].
// Revision : 1.0 - initial release
// Ports    : v       in  WIDTH  present node voltage (signed)
//            target  in  WIDTH  voltage the node relaxes toward (signed)
//            k       in  FRAC   step coefficient, unsigned Q0.FRAC
//            vmax    in  WIDTH  upper saturation bound (signed)
//            v_next  out WIDTH  voltage after one step
// ============================================================================
module rc_step
    import discrete_555_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int FRAC  = DEFAULT_FRAC
) (
    input  logic [WIDTH-1:0] v,
    input  logic [WIDTH-1:0] target,
    input  logic [FRAC-1:0]  k,
    input  logic [WIDTH-1:0] vmax,
    output logic [WIDTH-1:0] v_next
);

    // Wide enough that delta (WIDTH+1 bits) times k (FRAC bits, unsigned)
    // cannot overflow, and the sum before saturation cannot wrap.
    localparam int MW = WIDTH + FRAC + 2;

    logic signed [MW-1:0] w_v_ext;
    logic signed [MW-1:0] w_target_ext;
    logic signed [MW-1:0] w_vmax_ext;
    logic signed [MW-1:0] w_delta;
    logic signed [MW-1:0] w_product;
    logic signed [MW-1:0] w_step_raw;
    logic signed [MW-1:0] w_step;
    logic signed [MW-1:0] w_sum;

    always_comb begin
        w_v_ext      = MW'($signed(v));
        w_target_ext = MW'($signed(target));
        w_vmax_ext   = MW'($signed(vmax));
        w_delta      = w_target_ext - w_v_ext;
        w_product    = w_delta * $signed({{(MW-FRAC){1'b0}}, k});
        // Arithmetic shift floors toward minus infinity for negative deltas.
        w_step_raw   = w_product >>> FRAC;

        // A nonzero delta always moves the node by at least one LSB, so the
        // rails are reachable and the comparators can never stall.
        if (w_delta == '0) begin
            w_step = '0;
        end else if (w_step_raw == '0) begin
            w_step = w_delta[MW-1] ? '1 : MW'(1);
        end else begin
            w_step = w_step_raw;
        end

        w_sum = w_v_ext + w_step;

        if (w_sum > w_vmax_ext) begin
            v_next = vmax;
        end else if (w_sum[MW-1]) begin
            v_next = '0;
        end else begin
            v_next = w_sum[WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/cv_astable_555.sv
`default_nettype none
// ============================================================================
// Module   : cv_astable_555
// Purpose  : Behavioural 555 timer in astable mode with a control-voltage
//            input. The capacitor charges toward vcc until it reaches the
//            upper threshold, then discharges toward 0 until it reaches half
//            of that threshold.
// Revision : 1.0 - initial release
// Ports    : emu_clk        in   1         model timestep clock
//            emu_rst        in   1         asynchronous active-high reset
//            enable         in   1         555 reset pin, high = run
//            vcc            in   WIDTH     supply voltage
//            v_control      in   WIDTH     control-pin voltage
//            v_cap          out  WIDTH     timing-capacitor voltage
//            out_bit        out  1         output level (high while charging)
//            square_wave    out  WIDTH     vcc when out_bit=1, else 0
//            rise_pulse     out  1         strobe on DISCHARGE->CHARGE
//            period_cycles  out  PERIOD_W  cycles between last two rises
// ============================================================================
module cv_astable_555
    import discrete_555_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int FRAC        = DEFAULT_FRAC,
    parameter int K_CHARGE    = 655,
    parameter int K_DISCHARGE = 983,
    parameter int PERIOD_W    = 16
) (
    input  logic                emu_clk,
    input  logic                emu_rst,
    input  logic                enable,
    input  logic [WIDTH-1:0]    vcc,
    input  logic [WIDTH-1:0]    v_control,
    output logic [WIDTH-1:0]    v_cap,
    output logic                out_bit,
    output logic [WIDTH-1:0]    square_wave,
    output logic                rise_pulse,
    output logic [PERIOD_W-1:0] period_cycles
);

    localparam logic [FRAC-1:0] K_CHARGE_Q    = FRAC'(K_CHARGE);
    localparam logic [FRAC-1:0] K_DISCHARGE_Q = FRAC'(K_DISCHARGE);

    state_t                     state_q, state_d;
    logic signed [WIDTH-1:0]    v_cap_q, v_cap_d;
    logic                       out_bit_q, out_bit_d;
    logic [WIDTH-1:0]           square_wave_q, square_wave_d;
    logic                       rise_pulse_q, rise_pulse_d;
    logic [PERIOD_W-1:0]        period_q, period_d;
    logic [PERIOD_W-1:0]        counter_q, counter_d;

    logic signed [WIDTH-1:0]    w_thr;
    logic signed [WIDTH-1:0]    w_trg;
    logic [WIDTH-1:0]           w_target;
    logic [FRAC-1:0]            w_k;
    logic [WIDTH-1:0]           w_v_next;
    logic [PERIOD_W-1:0]        w_cnt_sat;

    // Comparator levels: the control pin sets the upper threshold directly,
    // clamped to the supply; the trigger level is half of it.
    always_comb begin
        if ($signed(v_control) < 0) begin
            w_thr = '0;
        end else if ($signed(v_control) > $signed(vcc)) begin
            w_thr = $signed(vcc);
        end else begin
            w_thr = $signed(v_control);
        end
        w_trg = w_thr >>> 1;
    end

    always_comb begin
        w_target = (state_q == CHARGE) ? vcc : '0;
        w_k      = (state_q == CHARGE) ? K_CHARGE_Q : K_DISCHARGE_Q;
    end

    rc_step #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_rc_step (
        .v      (v_cap_q),
        .target (w_target),
        .k      (w_k),
        .vmax   (vcc),
        .v_next (w_v_next)
    );

    // Next state; enable low overrides both comparators.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = CHARGE;
            end
            CHARGE: begin
                if (!enable)             state_d = IDLE;
                else if (v_cap_q >= w_thr) state_d = DISCHARGE;
            end
            DISCHARGE: begin
                if (!enable)             state_d = IDLE;
                else if (v_cap_q <= w_trg) state_d = CHARGE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        w_cnt_sat     = (&counter_q) ? counter_q : counter_q + 1'b1;
        v_cap_d       = $signed(w_v_next);
        out_bit_d     = (state_d == CHARGE);
        square_wave_d = out_bit_d ? vcc : '0;
        rise_pulse_d  = (state_q == DISCHARGE) && (state_d == CHARGE);
        counter_d     = w_cnt_sat;
        period_d      = period_q;

        if (rise_pulse_d) begin
            period_d  = w_cnt_sat;
            counter_d = '0;
        end else if ((state_q == IDLE) && (state_d == CHARGE)) begin
            // Leaving IDLE restarts the measurement without publishing a
            // period, since the interval did not span a full cycle.
            counter_d = '0;
        end
    end

    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            state_q       <= IDLE;
            v_cap_q       <= '0;
            out_bit_q     <= 1'b0;
            square_wave_q <= '0;
            rise_pulse_q  <= 1'b0;
            period_q      <= '0;
            counter_q     <= '0;
        end else begin
            state_q       <= state_d;
            v_cap_q       <= v_cap_d;
            out_bit_q     <= out_bit_d;
            square_wave_q <= square_wave_d;
            rise_pulse_q  <= rise_pulse_d;
            period_q      <= period_d;
            counter_q     <= counter_d;
        end
    end

    assign v_cap         = v_cap_q;
    assign out_bit       = out_bit_q;
    assign square_wave   = square_wave_q;
    assign rise_pulse    = rise_pulse_q;
    assign period_cycles = period_q;

endmodule
`default_nettype wire
